pc_redirect_unit: RTL and testbench



---
 rtl/pc_redirect_unit_pkg.sv | 18 +
 rtl/pc_target_mux.sv | 50 +++++
 rtl/pc_redirect_unit.sv | 103 ++++++++++
 tb/tb_pc_redirect_unit.sv | 124 ++++++++++++
 4 files changed

// File: rtl/pc_redirect_unit_pkg.sv
// Shared constants for the PC redirect unit: reset vector, FSM state encoding
// and the encoding of the next-PC target select.
package pc_redirect_unit_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;

    typedef logic state_t;
    localparam state_t RUN  = 1'b0;
    localparam state_t PEND = 1'b1;

    typedef enum logic [1:0] {
        SEL_SEQ = 2'd0,
        SEL_BR  = 2'd1,
        SEL_J   = 2'd2,
        SEL_JR  = 2'd3
    } tgt_sel_e;

endpackage

// File: rtl/pc_target_mux.sv
// Combinational redirect target: branch/jump/jr address generation, priority
// select (jr > j > branch) and word-alignment of the selected target.
module pc_target_mux
    import pc_redirect_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             jump_register,
    input  logic [WIDTH-1:0] resolve_pc4,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic [25:0]      jump_index,
    input  logic [WIDTH-1:0] jr_target,
    output logic             redirect,
    output logic [WIDTH-1:0] target,
    output logic             misaligned
);

    logic [WIDTH-1:0] br_target;
    logic [WIDTH-1:0] j_target;
    logic [WIDTH-1:0] raw_target;
    tgt_sel_e         sel;

    assign br_target = resolve_pc4 + (branch_offset << 2);
    assign j_target  = {resolve_pc4[WIDTH-1:28], jump_index, 2'b00};

    always_comb begin
        sel = SEL_SEQ;
        if (jump_register)     sel = SEL_JR;
        else if (jump)         sel = SEL_J;
        else if (branch_taken) sel = SEL_BR;
    end

    always_comb begin
        raw_target = '0;
        case (sel)
            SEL_BR:  raw_target = br_target;
            SEL_J:   raw_target = j_target;
            SEL_JR:  raw_target = jr_target;
            default: raw_target = '0;
        endcase
    end

    assign redirect   = (sel != SEL_SEQ);
    assign misaligned = redirect && (raw_target[1:0] != 2'b00);
    // Low bits are dropped so the fetch PC always stays word aligned.
    assign target     = {raw_target[WIDTH-1:2], 2'b00};

endmodule

// File: rtl/pc_redirect_unit.sv
// Fetch PC register with next-PC selection; a redirect arriving during a stall
// is parked in a pending register and applied when the stall releases.
module pc_redirect_unit
    import pc_redirect_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic             jump,
    input  logic             jump_register,
    input  logic [WIDTH-1:0] resolve_pc4,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic [25:0]      jump_index,
    input  logic [WIDTH-1:0] jr_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             flush,
    output logic             addr_error
);

    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] pc_reg, pc_next;
    logic [WIDTH-1:0] pending_reg, pending_next;
    logic             flush_reg, flush_next;
    logic             addr_error_reg, addr_error_next;

    logic             redirect;
    logic [WIDTH-1:0] target;
    logic             misaligned;

    pc_target_mux #(.WIDTH(WIDTH)) u_target_mux (
        .branch_taken  (branch_taken),
        .jump          (jump),
        .jump_register (jump_register),
        .resolve_pc4   (resolve_pc4),
        .branch_offset (branch_offset),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .redirect      (redirect),
        .target        (target),
        .misaligned    (misaligned)
    );

    always_ff @(posedge clk) begin
        if (reset) state_reg <= RUN;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            RUN:     if (stall && redirect) state_next = PEND;
            PEND:    if (!stall)            state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // In PEND the redirect inputs are stale copies of the captured one, so they are ignored.
    always_comb begin
        pc_next         = pc_reg;
        pending_next    = pending_reg;
        flush_next      = 1'b0;
        addr_error_next = addr_error_reg;
        case (state_reg)
            RUN: begin
                flush_next = redirect;
                if (redirect && misaligned) addr_error_next = 1'b1;
                if (!stall)        pc_next      = redirect ? target : pc_plus4;
                else if (redirect) pending_next = target;
            end
            PEND: begin
                if (!stall) pc_next = pending_reg;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg         <= RESET_PC;
            pending_reg    <= '0;
            flush_reg      <= 1'b0;
            addr_error_reg <= 1'b0;
        end else begin
            pc_reg         <= pc_next;
            pending_reg    <= pending_next;
            flush_reg      <= flush_next;
            addr_error_reg <= addr_error_next;
        end
    end

    assign pc         = pc_reg;
    assign pc_plus4   = pc_reg + PC_STEP;
    assign flush      = flush_reg;
    assign addr_error = addr_error_reg;

endmodule

// File: tb/tb_pc_redirect_unit.sv
// Scoreboard bench for pc_redirect_unit: expected pc/flush/addr_error are queued
// with each stimulus cycle and compared one time unit after the clock edge.
module tb_pc_redirect_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic        jump = 1'b0;
    logic        jump_register = 1'b0;
    logic [31:0] resolve_pc4 = '0;
    logic [31:0] branch_offset = '0;
    logic [25:0] jump_index = '0;
    logic [31:0] jr_target = '0;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        flush;
    logic        addr_error;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        flush;
        logic        aerr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_redirect_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .jump          (jump),
        .jump_register (jump_register),
        .resolve_pc4   (resolve_pc4),
        .branch_offset (branch_offset),
        .jump_index    (jump_index),
        .jr_target     (jr_target),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .flush         (flush),
        .addr_error    (addr_error)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, then compare after the edge.
    task automatic cycle(input string tag, input logic rst, input logic stl,
                         input logic br, input logic j, input logic jr,
                         input logic [31:0] exp_pc, input logic exp_flush, input logic exp_aerr);
        exp_t e;
        exp_t o;
        reset = rst; stall = stl; branch_taken = br; jump = j; jump_register = jr;
        e.tag = tag; e.pc = exp_pc; e.flush = exp_flush; e.aerr = exp_aerr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        o = exp_q.pop_front();
        check_eq({o.tag, ".pc"},    pc,                 o.pc);
        check_eq({o.tag, ".pc4"},   pc_plus4,           o.pc + 32'd4);
        check_eq({o.tag, ".flush"}, {31'd0, flush},     {31'd0, o.flush});
        check_eq({o.tag, ".aerr"},  {31'd0, addr_error}, {31'd0, o.aerr});
        $display("txn %-10s pc=%h flush=%0b aerr=%0b", o.tag, pc, flush, addr_error);
    endtask

    initial begin
        @(posedge clk);
        #1;
        cycle("reset",   1, 0, 0, 0, 0, 32'h0040_0000, 0, 0);
        cycle("seq1",    0, 0, 0, 0, 0, 32'h0040_0004, 0, 0);
        cycle("seq2",    0, 0, 0, 0, 0, 32'h0040_0008, 0, 0);
        cycle("seq3",    0, 0, 0, 0, 0, 32'h0040_000C, 0, 0);

        resolve_pc4 = 32'h0040_0010; branch_offset = 32'hFFFF_FFFE;
        cycle("branch",  0, 0, 1, 0, 0, 32'h0040_0008, 1, 0);
        cycle("br_after",0, 0, 0, 0, 0, 32'h0040_000C, 0, 0);

        resolve_pc4 = 32'h0040_0020; jump_index = 26'h010_0040; branch_offset = 32'h0000_0010;
        cycle("jump",    0, 0, 1, 1, 0, 32'h0040_0100, 1, 0);
        cycle("j_after", 0, 0, 0, 0, 0, 32'h0040_0104, 0, 0);

        jr_target = 32'h0040_0200;
        cycle("st_jr",   0, 1, 0, 0, 1, 32'h0040_0104, 1, 0);
        jr_target = 32'h0040_0500;
        cycle("st_hold1",0, 1, 0, 0, 1, 32'h0040_0104, 0, 0);
        cycle("st_hold2",0, 1, 0, 0, 1, 32'h0040_0104, 0, 0);
        cycle("st_rel",  0, 0, 0, 0, 0, 32'h0040_0200, 0, 0);
        cycle("rel_seq", 0, 0, 0, 0, 0, 32'h0040_0204, 0, 0);

        jr_target = 32'h0040_0203;
        cycle("jr_mis",  0, 0, 0, 0, 1, 32'h0040_0200, 1, 1);
        for (int i = 1; i <= 10; i++)
            cycle("sticky",  0, 0, 0, 0, 0, 32'h0040_0200 + 32'(4 * i), 0, 1);
        cycle("rst_aerr",1, 0, 0, 0, 0, 32'h0040_0000, 0, 0);

        jr_target = 32'h0040_0300;
        cycle("pend_cap",0, 1, 0, 0, 1, 32'h0040_0000, 1, 0);
        cycle("pend_hld",0, 1, 0, 0, 0, 32'h0040_0000, 0, 0);
        cycle("pend_rst",1, 1, 0, 0, 0, 32'h0040_0000, 0, 0);
        cycle("post_rst",0, 0, 0, 0, 0, 32'h0040_0004, 0, 0);
        cycle("post_2",  0, 0, 0, 0, 0, 32'h0040_0008, 0, 0);
        cycle("post_3",  0, 0, 0, 0, 0, 32'h0040_000C, 0, 0);

        jr_target = 32'hFFFF_FFFC;
        cycle("jr_top",  0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 0);
        cycle("wrap",    0, 0, 0, 0, 0, 32'h0000_0000, 0, 0);

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
